// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - opcode, phase and state definitions shared by the RISC sequencer and ALU
// Contents: OP_* opcode encodings, PH_* phase encodings, sequencer state enum, ALUOP decode.
package risc_pkg;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  localparam logic [2:0] PH_0 = 3'd0;
  localparam logic [2:0] PH_1 = 3'd1;
  localparam logic [2:0] PH_2 = 3'd2;
  localparam logic [2:0] PH_3 = 3'd3;
  localparam logic [2:0] PH_4 = 3'd4;
  localparam logic [2:0] PH_5 = 3'd5;
  localparam logic [2:0] PH_6 = 3'd6;
  localparam logic [2:0] PH_7 = 3'd7;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // Instructions that read a memory operand and load the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/risc_phase_cnt.sv
// rtl/risc_phase_cnt.sv - 3-bit wrapping instruction phase counter
// Ports:
//   i_clk   in   clock, rising edge
//   i_rst   in   asynchronous active-high reset, forces PH_0
//   i_hold  in   freeze the count (asserted while halted)
//   i_clr   in   synchronous return to PH_0 (takes priority over i_hold)
//   o_phase out  phase whose outputs are decoded on the next edge
module risc_phase_cnt
  import risc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_hold,
  input  logic       i_clr,
  output logic [2:0] o_phase
);

  logic [2:0] r_phase;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase <= PH_0;
    end else if (i_clr) begin
      r_phase <= PH_0;
    end else if (!i_hold) begin
      r_phase <= r_phase + 3'd1;
    end
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/risc_ctrl.sv
// rtl/risc_ctrl.sv - 8-phase fetch/decode/execute sequencer for the accumulator RISC CPU
// Optional feature macro: RISC_CTRL_RESUME_EN (adds resume port to leave HALTED).
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   asynchronous active-high reset
//   opcode in   IR opcode, sampled entering phase 4
//   zero   in   ALU zero flag, sampled entering phase 6
//   resume in   leave HALTED (RISC_CTRL_RESUME_EN only)
//   sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt  out  registered control strobes
module risc_ctrl
  import risc_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic       zero,
`ifdef RISC_CTRL_RESUME_EN
  input  logic       resume,
`endif
  output logic       sel,
  output logic       rd,
  output logic       wr,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       data_e,
  output logic       halt
);

  // r_phase names the phase whose outputs get registered on the next edge,
  // so the strobes lag the counter by one clock and stay fully registered.
  logic [2:0] w_phase;
  state_t     r_state, w_state_nxt;
  logic [2:0] r_opcode;
  logic       r_zero;
  logic       w_hold, w_clr;
  logic       w_sel, w_rd, w_wr, w_ld_ir, w_ld_ac, w_inc_pc, w_ld_pc, w_data_e, w_halt;
  logic       r_sel, r_rd, r_wr, r_ld_ir, r_ld_ac, r_inc_pc, r_ld_pc, r_data_e, r_halt;

  risc_phase_cnt u_phase_cnt (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_hold  (w_hold),
    .i_clr   (w_clr),
    .o_phase (w_phase)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_opcode <= OP_HLT;
      r_zero   <= 1'b0;
      r_sel    <= 1'b0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_ld_ir  <= 1'b0;
      r_ld_ac  <= 1'b0;
      r_inc_pc <= 1'b0;
      r_ld_pc  <= 1'b0;
      r_data_e <= 1'b0;
      r_halt   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel;
      r_rd     <= w_rd;
      r_wr     <= w_wr;
      r_ld_ir  <= w_ld_ir;
      r_ld_ac  <= w_ld_ac;
      r_inc_pc <= w_inc_pc;
      r_ld_pc  <= w_ld_pc;
      r_data_e <= w_data_e;
      r_halt   <= w_halt;
      if (r_state == ST_RUN && w_phase == PH_4) r_opcode <= opcode;
      // Holding zero across phases 6-7 keeps a skip from being half-applied.
      if (r_state == ST_RUN && w_phase == PH_6) r_zero <= zero;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold      = 1'b0;
    w_clr       = 1'b0;
    w_sel       = 1'b0;
    w_rd        = 1'b0;
    w_wr        = 1'b0;
    w_ld_ir     = 1'b0;
    w_ld_ac     = 1'b0;
    w_inc_pc    = 1'b0;
    w_ld_pc     = 1'b0;
    w_data_e    = 1'b0;
    w_halt      = 1'b0;
    case (r_state)
      ST_RUN: begin
        case (w_phase)
          PH_0: w_sel = 1'b1;
          PH_1: begin
            w_sel = 1'b1;
            w_rd  = 1'b1;
          end
          PH_2, PH_3: begin
            w_sel   = 1'b1;
            w_rd    = 1'b1;
            w_ld_ir = 1'b1;
          end
          PH_4: begin
            // Live opcode here: this is the edge that captures it.
            w_inc_pc = 1'b1;
            if (opcode == OP_HLT) begin
              w_halt      = 1'b1;
              w_state_nxt = ST_HALTED;
              w_clr       = 1'b1;
            end
          end
          PH_5: w_rd = is_aluop(r_opcode);
          PH_6: begin
            w_rd     = is_aluop(r_opcode);
            w_inc_pc = (r_opcode == OP_SKZ) && zero;
            w_ld_pc  = (r_opcode == OP_JMP);
            w_data_e = (r_opcode == OP_STO);
          end
          PH_7: begin
            w_rd     = is_aluop(r_opcode);
            w_ld_ac  = is_aluop(r_opcode);
            w_inc_pc = (r_opcode == OP_SKZ) && r_zero;
            w_ld_pc  = (r_opcode == OP_JMP);
            w_wr     = (r_opcode == OP_STO);
            w_data_e = (r_opcode == OP_STO);
          end
          default: ;
        endcase
      end
      ST_HALTED: begin
        // Counter was parked at PH_0 on entry, so resuming starts a fresh fetch.
        w_hold = 1'b1;
        w_halt = 1'b1;
`ifdef RISC_CTRL_RESUME_EN
        if (resume) begin
          w_state_nxt = ST_RUN;
          w_hold      = 1'b0;
          w_halt      = 1'b0;
          w_sel       = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  assign sel    = r_sel;
  assign rd     = r_rd;
  assign wr     = r_wr;
  assign ld_ir  = r_ld_ir;
  assign ld_ac  = r_ld_ac;
  assign inc_pc = r_inc_pc;
  assign ld_pc  = r_ld_pc;
  assign data_e = r_data_e;
  assign halt   = r_halt;

endmodule

// File: tb/tb_risc_ctrl.sv
// tb/tb_risc_ctrl.sv - self-checking scoreboard bench for risc_ctrl
module tb_risc_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] opcode = 3'b000;
  logic       zero = 1'b0;
  logic       resume = 1'b0;
  logic       sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt;

  int checks = 0;
  int errors = 0;

  // Vector order: sel rd wr ld_ir ld_ac inc_pc ld_pc data_e halt
  localparam logic [8:0] V_NONE = 9'h000;
  localparam logic [8:0] V_F0   = 9'h100;
  localparam logic [8:0] V_F1   = 9'h180;
  localparam logic [8:0] V_F23  = 9'h1A0;
  localparam logic [8:0] V_INC  = 9'h008;
  localparam logic [8:0] V_HLT4 = 9'h009;
  localparam logic [8:0] V_RD   = 9'h080;
  localparam logic [8:0] V_RDAC = 9'h090;
  localparam logic [8:0] V_DE   = 9'h002;
  localparam logic [8:0] V_WRDE = 9'h042;
  localparam logic [8:0] V_LDPC = 9'h004;
  localparam logic [8:0] V_HALT = 9'h001;

  logic [8:0] sb_q[$];
  logic [8:0] obs;
  logic [8:0] exp_v;

  assign obs = {sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt};

  always #5 clock = ~clock;

  risc_ctrl dut (
    .clock  (clock),
    .reset  (reset),
    .opcode (opcode),
    .zero   (zero),
`ifdef RISC_CTRL_RESUME_EN
    .resume (resume),
`endif
    .sel    (sel),
    .rd     (rd),
    .wr     (wr),
    .ld_ir  (ld_ir),
    .ld_ac  (ld_ac),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .data_e (data_e),
    .halt   (halt)
  );

  task automatic push_instr(input logic [8:0] e4, input logic [8:0] e5,
                            input logic [8:0] e6, input logic [8:0] e7);
    sb_q.push_back(V_F0);
    sb_q.push_back(V_F1);
    sb_q.push_back(V_F23);
    sb_q.push_back(V_F23);
    sb_q.push_back(e4);
    sb_q.push_back(e5);
    sb_q.push_back(e6);
    sb_q.push_back(e7);
  endtask

  task automatic pop_exp(output logic [8:0] e);
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got nothing required entry");
      e = 9'h1FF;
    end else begin
      e = sb_q.pop_front();
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clock);
    checks++;
    if (obs !== V_NONE) begin
      errors++;
      $display("FAIL reset_outputs got %h required %h", obs, V_NONE);
    end
    reset = 1'b0;
  endtask

  task automatic test_alu(input logic [2:0] op, input string name);
    opcode = op;
    push_instr(V_INC, V_RD, V_RD, V_RDAC);
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      @(negedge clock);
      pop_exp(exp_v);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s phase %0d got %h required %h", name, i, obs, exp_v);
      end
    end
  endtask

  task automatic test_sto;
    opcode = 3'b110;
    push_instr(V_INC, V_NONE, V_DE, V_WRDE);
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      @(negedge clock);
      pop_exp(exp_v);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL sto phase %0d got %h required %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_skz(input logic z, input logic toggle, input string name);
    opcode = 3'b001;
    zero   = z;
    push_instr(V_INC, V_NONE, z ? V_INC : V_NONE, z ? V_INC : V_NONE);
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      @(negedge clock);
      pop_exp(exp_v);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s phase %0d got %h required %h", name, i, obs, exp_v);
      end
      if (toggle && i == 6) zero = ~zero;
    end
    zero = 1'b0;
  endtask

  task automatic test_jmp;
    opcode = 3'b111;
    push_instr(V_INC, V_NONE, V_LDPC, V_LDPC);
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      @(negedge clock);
      pop_exp(exp_v);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL jmp phase %0d got %h required %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_sto;
    opcode = 3'b110;
    push_instr(V_INC, V_NONE, V_DE, V_WRDE);
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      @(negedge clock);
      pop_exp(exp_v);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL sto_pre_reset phase %0d got %h required %h", i, obs, exp_v);
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== V_NONE) begin
      errors++;
      $display("FAIL async_reset_wr got %h required %h", obs, V_NONE);
    end
    #1;
    reset = 1'b0;
  endtask

  task automatic test_hlt;
    opcode = 3'b000;
    sb_q.push_back(V_F0);
    sb_q.push_back(V_F1);
    sb_q.push_back(V_F23);
    sb_q.push_back(V_F23);
    sb_q.push_back(V_HLT4);
    repeat (20) sb_q.push_back(V_HALT);
    for (int i = 0; i < 25; i++) begin
      @(posedge clock);
      @(negedge clock);
      pop_exp(exp_v);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL hlt cycle %0d got %h required %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_resume;
`ifdef RISC_CTRL_RESUME_EN
    opcode = 3'b010;
    resume = 1'b1;
    sb_q.push_back(V_F0);
    sb_q.push_back(V_F1);
    sb_q.push_back(V_F23);
    sb_q.push_back(V_F23);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      @(negedge clock);
      resume = 1'b0;
      pop_exp(exp_v);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL resume phase %0d got %h required %h", i, obs, exp_v);
      end
    end
`else
    repeat (3) sb_q.push_back(V_HALT);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      @(negedge clock);
      pop_exp(exp_v);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL stay_halted cycle %0d got %h required %h", i, obs, exp_v);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_alu(3'b010, "add");
    test_sto();
    test_skz(1'b1, 1'b0, "skz_z1");
    test_skz(1'b0, 1'b0, "skz_z0");
    test_skz(1'b1, 1'b1, "skz_toggle");
    test_jmp();
    test_alu(3'b101, "lda_back_to_back");
    test_reset_mid_sto();
    test_hlt();
    test_resume();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
